// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - sweeps a/b over all four vectors and checks the seven gate outputs
// Every output is registered; the FSM runs IDLE -> (WAIT -> CHECK) x 4 x NUM_PASSES -> FINISH.
module gate_sweep_checker #(
    parameter int NUM_PASSES = 1,
    parameter int SETTLE     = 1,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic             and_in,
    input  logic             or_in,
    input  logic             not_in,
    input  logic             nand_in,
    input  logic             nor_in,
    input  logic             xor_in,
    input  logic             xnor_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec,
    output logic [6:0]       mismatch_mask
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, FINISH} state_t;

    state_t           state_q;
    logic             a_q, b_q, busy_q, done_q, pass_q;
    logic [ERR_W-1:0] err_q;
    logic [3:0]       fail_vec_q;
    logic [6:0]       mask_q;
    logic [1:0]       vec_q;
    logic [PW-1:0]    pass_idx_q;
    logic [SW-1:0]    settle_q;

    logic [6:0] expected_d, observed_d, diff_d;
    logic [1:0] vec_next_d;

    always_comb begin
        expected_d = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q), ~a_q, a_q | b_q, a_q & b_q};
        observed_d = {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in};
        diff_d     = expected_d ^ observed_d;
        vec_next_d = vec_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_vec_q <= '0;
            mask_q     <= '0;
            vec_q      <= '0;
            pass_idx_q <= '0;
            settle_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q      <= '0;
                        fail_vec_q <= '0;
                        mask_q     <= '0;
                        pass_q     <= 1'b0;
                        a_q        <= 1'b0;
                        b_q        <= 1'b0;
                        vec_q      <= '0;
                        pass_idx_q <= '0;
                        settle_q   <= SW'(SETTLE - 1);
                        busy_q     <= 1'b1;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (settle_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                CHECK: begin
                    // One error per failing vector, regardless of how many gate bits differ.
                    if (diff_d != '0) begin
                        mask_q               <= mask_q | diff_d;
                        fail_vec_q[{a_q, b_q}] <= 1'b1;
                        if (err_q != '1) begin
                            err_q <= err_q + 1'b1;
                        end
                    end
                    if (vec_q != 2'd3) begin
                        vec_q    <= vec_next_d;
                        a_q      <= vec_next_d[1];
                        b_q      <= vec_next_d[0];
                        settle_q <= SW'(SETTLE - 1);
                        state_q  <= WAIT;
                    end else if (pass_idx_q != PW'(NUM_PASSES - 1)) begin
                        pass_idx_q <= pass_idx_q + 1'b1;
                        vec_q      <= '0;
                        a_q        <= 1'b0;
                        b_q        <= 1'b0;
                        settle_q   <= SW'(SETTLE - 1);
                        state_q    <= WAIT;
                    end else begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == '0);
                    busy_q  <= 1'b0;
                    a_q     <= 1'b0;
                    b_q     <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_out         = a_q;
    assign b_out         = b_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign fail_vec      = fail_vec_q;
    assign mismatch_mask = mask_q;
endmodule
